// File: rtl/commit_trace_buffer_pkg.sv
// trace_pkg: trace entry type and sizing helpers shared by the commit trace buffer.
// Entry fields are sized to the widest supported configuration; narrower builds zero-extend.
package trace_pkg;
    localparam int NUM_ARCH_REGS = 32;
    localparam int WNUM_W = $clog2(NUM_ARCH_REGS);
    localparam int PC_MAX_W = 64;
    localparam int DATA_MAX_W = 64;
    localparam int SEQ_MAX_W = 32;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [WNUM_W-1:0] wnum;
        logic [DATA_MAX_W-1:0] wdata;
        logic [SEQ_MAX_W-1:0] seq;
    } trace_entry_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/commit_trace_buffer_if.sv
// commit_trace_buffer_if: core-side trace beats in, harness-side stream and status out.
interface commit_trace_buffer_if
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PC_W = 64,
    parameter int DATA_W = 64,
    parameter int SEQ_W = 32
) ();
    logic clear;
    logic in_commit;
    logic [PC_W-1:0] in_pc;
    logic [WNUM_W-1:0] in_wnum;
    logic [DATA_W-1:0] in_wdata;
    logic out_valid;
    logic out_ready;
    logic [PC_W-1:0] out_pc;
    logic [WNUM_W-1:0] out_wnum;
    logic [DATA_W-1:0] out_wdata;
    logic [SEQ_W-1:0] out_seq;
    logic [lvl_w(DEPTH)-1:0] level;
    logic overflow;
    logic [SEQ_W-1:0] drop_count;

    modport master (
        output clear, in_commit, in_pc, in_wnum, in_wdata, out_ready,
        input out_valid, out_pc, out_wnum, out_wdata, out_seq, level, overflow, drop_count
    );
    modport slave (
        input clear, in_commit, in_pc, in_wnum, in_wdata, out_ready,
        output out_valid, out_pc, out_wnum, out_wdata, out_seq, level, overflow, drop_count
    );
endinterface

// File: rtl/commit_trace_buffer_fifo.sv
// trace_fifo: first-word-fall-through FIFO of trace entries with wrap-bit pointers.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic push_i,
    input  logic pop_i,
    input  trace_entry_t data_i,
    output trace_entry_t data_o,
    output logic full_o,
    output logic empty_o,
    output logic [lvl_w(DEPTH)-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    trace_entry_t mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic do_push, do_pop;

    assign empty_o = wptr_q == rptr_q;
    assign full_o = wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]};
    assign do_pop = pop_i && !empty_o && !clear_i;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop) && !clear_i;
    assign level_o = wptr_q - rptr_q;
    assign data_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = clear_i ? '0 : wptr_q + PW'(do_push);
        rptr_d = clear_i ? '0 : rptr_q + PW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: buffers retired-instruction trace beats for the difftest harness,
// tagging each with a sequence number and dropping (and counting) beats on overflow.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PC_W = 64,
    parameter int DATA_W = 64,
    parameter int SEQ_W = 32
) (
    input logic clock,
    input logic reset,
    commit_trace_buffer_if.slave bus
);
    trace_entry_t wr_entry, head;
    logic full, empty, pop, push, drop;
    logic [SEQ_W-1:0] seq_q, seq_d, drop_cnt_q, drop_cnt_d;
    logic overflow_q, overflow_d;
    logic [lvl_w(DEPTH)-1:0] fifo_level;

    assign pop = !empty && bus.out_ready;
    assign push = bus.in_commit && (!full || pop);
    assign drop = bus.in_commit && full && !pop;
    assign wr_entry = '{
        pc: PC_MAX_W'(bus.in_pc),
        wnum: bus.in_wnum,
        wdata: DATA_MAX_W'(bus.in_wdata),
        seq: SEQ_MAX_W'(seq_q)
    };

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i(clock),
        .rst_ni(reset),
        .clear_i(bus.clear),
        .push_i(push),
        .pop_i(pop),
        .data_i(wr_entry),
        .data_o(head),
        .full_o(full),
        .empty_o(empty),
        .level_o(fifo_level)
    );

    // Every commit consumes a sequence number, dropped or not, so gaps are visible downstream.
    always_comb begin
        seq_d = bus.clear ? '0 : seq_q + SEQ_W'(bus.in_commit);
        overflow_d = !bus.clear && (overflow_q || drop);
        drop_cnt_d = bus.clear ? '0 : drop_cnt_q + SEQ_W'(drop && !(&drop_cnt_q));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seq_q <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            seq_q <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Head fields are gated by valid so stale storage never leaks after reset or clear.
    assign bus.out_valid = !empty;
    assign bus.out_pc = empty ? '0 : head.pc[PC_W-1:0];
    assign bus.out_wnum = empty ? '0 : head.wnum;
    assign bus.out_wdata = (empty || head.wnum == '0) ? '0 : head.wdata[DATA_W-1:0];
    assign bus.out_seq = empty ? '0 : head.seq[SEQ_W-1:0];
    assign bus.level = fifo_level;
    assign bus.overflow = overflow_q;
    assign bus.drop_count = drop_cnt_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed scenarios plus a random phase, checked against a queue-based model.
module tb_commit_trace_buffer;
    localparam int DEPTH = 16;

    typedef struct {
        logic [63:0] pc;
        logic [4:0] wn;
        logic [63:0] wd;
        logic [31:0] seq;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    commit_trace_buffer_if #(.DEPTH(DEPTH)) bus ();
    commit_trace_buffer #(.DEPTH(DEPTH)) dut (.clock(clk), .reset(rst_n), .bus(bus));

    beat_t q[$];
    logic [31:0] dut_pops[$];
    logic [31:0] m_seq, m_drop;
    logic m_ovf;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_seq = 0;
        m_drop = 0;
        m_ovf = 1'b0;
    endtask

    task automatic check_state();
        chk("valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("level", 64'(bus.level), 64'(q.size()));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        chk("drop_count", 64'(bus.drop_count), 64'(m_drop));
        if (q.size() != 0) begin
            chk("pc", bus.out_pc, q[0].pc);
            chk("wnum", 64'(bus.out_wnum), 64'(q[0].wn));
            chk("wdata", bus.out_wdata, q[0].wn == 0 ? 64'd0 : q[0].wd);
            chk("seq", 64'(bus.out_seq), 64'(q[0].seq));
        end
    endtask

    // Drive one cycle from a negedge, advance the model by the spec's rules, check at next negedge.
    task automatic cycle(input logic c, input logic [63:0] pc, input logic [4:0] wn,
                         input logic [63:0] wd, input logic rdy, input logic clr = 1'b0);
        bit pop, take;
        bus.in_commit = c;
        bus.in_pc = pc;
        bus.in_wnum = wn;
        bus.in_wdata = wd;
        bus.out_ready = rdy;
        bus.clear = clr;
        if (!clr && bus.out_valid && rdy) dut_pops.push_back(bus.out_seq);
        @(posedge clk);
        if (clr) model_reset();
        else begin
            pop = q.size() != 0 && rdy;
            take = c && (q.size() < DEPTH || pop);
            if (pop) void'(q.pop_front());
            if (c) begin
                if (take) q.push_back('{pc, wn, wd, m_seq});
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != 32'hFFFF_FFFF) m_drop++;
                end
                m_seq++;
            end
        end
        @(negedge clk);
        bus.clear = 1'b0;
        check_state();
    endtask

    task automatic rnd_beat(input logic c, input logic rdy);
        cycle(c, {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom}, rdy);
    endtask

    initial begin
        bus.clear = 1'b0;
        bus.in_commit = 1'b0;
        bus.in_pc = '0;
        bus.in_wnum = '0;
        bus.in_wdata = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_level", 64'(bus.level), 64'd0);
        chk("rst_pc", bus.out_pc, 64'd0);
        chk("rst_wdata", bus.out_wdata, 64'd0);
        chk("rst_seq", 64'(bus.out_seq), 64'd0);
        chk("rst_drop", 64'(bus.drop_count), 64'd0);
        rst_n = 1'b1;

        // First beat visible next cycle.
        cycle(1'b1, 64'h8000_0000, 5'd5, 64'h1234, 1'b0);
        chk("t1_pc", bus.out_pc, 64'h8000_0000);
        chk("t1_wdata", bus.out_wdata, 64'h1234);
        chk("t1_seq", 64'(bus.out_seq), 64'd0);
        chk("t1_level", 64'(bus.level), 64'd1);

        // x0 write data masked.
        cycle(1'b1, 64'h8000_0004, 5'd0, 64'hDEAD, 1'b1);
        chk("t2_wnum", 64'(bus.out_wnum), 64'd0);
        chk("t2_wdata", bus.out_wdata, 64'd0);
        cycle(1'b0, 64'd0, 5'd0, 64'd0, 1'b1);
        chk("t2_empty", 64'(bus.out_valid), 64'd0);

        // Overflow by one, then drain and observe the sequence gap.
        cycle(1'b0, 64'd0, 5'd0, 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) rnd_beat(1'b1, 1'b0);
        chk("t3_level", 64'(bus.level), 64'd16);
        chk("t3_ovf", 64'(bus.overflow), 64'd1);
        chk("t3_drop", 64'(bus.drop_count), 64'd1);
        dut_pops.delete();
        for (int i = 0; i < 16; i++) rnd_beat(1'b0, 1'b1);
        chk("t3_drain_cnt", 64'(dut_pops.size()), 64'd16);
        for (int i = 0; i < 16 && i < dut_pops.size(); i++) chk("t3_drain_seq", 64'(dut_pops[i]), 64'(i));
        rnd_beat(1'b1, 1'b0);
        chk("t3_next_seq", 64'(bus.out_seq), 64'd17);

        // Full with simultaneous push and pop is not a drop.
        cycle(1'b0, 64'd0, 5'd0, 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) rnd_beat(1'b1, 1'b0);
        rnd_beat(1'b1, 1'b1);
        chk("t4_level", 64'(bus.level), 64'd16);
        chk("t4_ovf", 64'(bus.overflow), 64'd0);
        chk("t4_drop", 64'(bus.drop_count), 64'd0);

        // Toggling ready during a 10-beat burst keeps order.
        cycle(1'b0, 64'd0, 5'd0, 64'd0, 1'b0, 1'b1);
        dut_pops.delete();
        for (int i = 0; i < 10; i++) rnd_beat(1'b1, 1'(i % 2 == 0));
        for (int i = 0; i < 40 && bus.out_valid; i++) rnd_beat(1'b0, 1'(i % 2 == 0));
        chk("t5_cnt", 64'(dut_pops.size()), 64'd10);
        for (int i = 0; i < 10 && i < dut_pops.size(); i++) chk("t5_seq", 64'(dut_pops[i]), 64'(i));

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 7; i++) rnd_beat(1'b1, 1'b0);
        chk("t6_level", 64'(bus.level), 64'd7);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_async_level", 64'(bus.level), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rnd_beat(1'b1, 1'b0);
        chk("t6_seq", 64'(bus.out_seq), 64'd0);

        // Random traffic: first half congested, second half mostly draining, occasional clear.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(63) == 0) cycle(1'b0, 64'd0, 5'd0, 64'd0, 1'b0, 1'b1);
            else rnd_beat(1'($urandom_range(9) < 7), 1'($urandom_range(99) < (n < 200 ? 30 : 80)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the CPU top-level debug port.
- Captures each retired-instruction trace beat (debug_commit, debug_pc, debug_rf_wnum, debug_rf_wdata) into a first-word-fall-through FIFO.
- Presents the buffered beats to the simulation/difftest harness over a valid/ready stream, tagged with a sequence number.
- The core cannot be stalled by the trace path. On overflow the block drops beats, flags the loss, and counts the dropped beats.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- PC_W, 64, trace PC width.
- DATA_W, 64, register write-data width.
- SEQ_W, 32, sequence-number width.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- clear  in  1  synchronous clear of FIFO, counters and sticky flag.
- in_commit  in  1  trace beat valid (from debug_commit).
- in_pc  in  PC_W  retired PC.
- in_wnum  in  5  destination register number.
- in_wdata  in  DATA_W  destination write data.
- out_valid  out  1  head entry available.
- out_ready  in  1  harness accepts head entry.
- out_pc  out  PC_W  head PC.
- out_wnum  out  5  head register number.
- out_wdata  out  DATA_W  head write data; forced 0 when out_wnum==0.
- out_seq  out  SEQ_W  head sequence number.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one beat dropped.
- drop_count  out  SEQ_W  number of dropped beats, saturating.

Behaviour:
- Reset (reset==0, async): FIFO empty, pointers 0, out_valid=0, level=0, overflow=0, drop_count=0, seq counter=0. Data outputs = 0.
- clear=1 has the same effect as reset but is synchronous. It takes priority over push/pop in that cycle.
- Push:
  - Every cycle with in_commit=1 assigns seq = seq_ctr, then seq_ctr increments (wraps modulo 2^SEQ_W).
  - The beat is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the beat is dropped, overflow is set, and drop_count increments (saturates at all-ones).
  - Dropped beats still consume a sequence number, so the harness sees a gap.
- Pop: occurs when out_valid && out_ready. It advances the read pointer.
- Latency: a beat pushed in cycle N is visible at the outputs in cycle N+1 at the earliest. No same-cycle bypass when empty.
- out_* registers show the head entry whenever out_valid=1. Values are held stable while out_valid && !out_ready.
- Simultaneous push and pop: level unchanged. Full+push+pop is accepted. Empty+push gives no pop, because out_valid=0.
- Pointers: log2(DEPTH)+1 bits with wrap bit. full = same index and differing wrap bit; empty = pointers equal.
- level = wptr - rptr (modulo), range 0..DEPTH.
- Reset mid-operation: all buffered beats are discarded. out_valid falls asynchronously.

Decomposition:
- Package trace_pkg:
  - Struct trace_entry_t {pc, wnum, wdata, seq}.
  - Constant NUM_ARCH_REGS=32.
  - Function for width of the level counter.
- Sub-module trace_fifo: generic FWFT FIFO of trace_entry_t with push/pop/full/empty/level.
- commit_trace_buffer contains the sequence counter, drop logic and x0 data masking.

Test Plan:
- Reset, then one beat with in_pc=0x8000_0000, wnum=5, wdata=0x1234 → next cycle out_valid=1, out_pc=0x8000_0000, out_wdata=0x1234, out_seq=0, level=1.
- Beat with wnum=0, wdata=0xDEAD, out_ready=1 → out_wnum=0, out_wdata=0; FIFO empties after the handshake.
- out_ready=0 with 17 consecutive commits (DEPTH=16) → level=16, overflow=1, drop_count=1. Draining yields seq 0..15. The next push gets seq 17.
- FIFO full, in_commit=1 and out_ready=1 in the same cycle → no drop, level stays 16, overflow stays 0.
- out_ready toggling 1,0,1,0 during a 10-beat burst → all 10 beats delivered in order with seq 0..9, and outputs stable while stalled.
- reset pulled low mid-burst with level=7 → out_valid=0 immediately. After release, level=0, and the next beat gets seq=0.
